// File: rtl/nbcac_pkg.sv
// nbcac_pkg
//   Shared constants and elaboration-time helpers for the pipelined NBCAC
//   (Fibonacci-weighted) encoder.
//   nbcac_weight(code_w, k) : weight of code bit d[k] (k = 1..code_w)
//   nbcac_capacity(code_w)  : sum of all weights (largest encodable value)
//   nbcac_res_w(code_w)     : residual width able to hold 0..capacity
package nbcac_pkg;

  // Smallest codeword the weight recurrence is defined for.
  localparam int NBCAC_MIN_CODE_W = 4;

  // w[1]=1, w[n]=w[n-1]=2, w[k]=w[k+1]+w[k+2] for 2 <= k <= n-2.
  function automatic int nbcac_weight(input int code_w, input int k);
    int w;
    int nxt;
    int nxt2;
    w    = 0;
    nxt  = 2;
    nxt2 = 2;
    if (k == 1) begin
      w = 1;
    end else if (k >= code_w - 1) begin
      w = 2;
    end else begin
      // Walk down from the top two weights; nxt holds w[j+1], nxt2 w[j+2].
      for (int j = code_w - 2; j >= k; j--) begin
        w    = nxt + nxt2;
        nxt2 = nxt;
        nxt  = w;
      end
    end
    return w;
  endfunction

  // Sum of all weights: the largest value a codeword can represent.
  function automatic int nbcac_capacity(input int code_w);
    int sum;
    sum = 0;
    for (int k = 1; k <= code_w; k++) begin
      sum = sum + nbcac_weight(code_w, k);
    end
    return sum;
  endfunction

  // Residual width: enough bits for any value 0..capacity.
  function automatic int nbcac_res_w(input int code_w);
    return $clog2(nbcac_capacity(code_w) + 1);
  endfunction

endpackage

// File: rtl/nbcac_enc_stage.sv
// nbcac_enc_stage
//   One registered bit-decision stage (code bit d[STAGE]) of the NBCAC encoder.
//   Ports:
//     clk, rst_n            : clock, async active-low reset
//     prev_valid/code/res   : contents of the preceding stage register
//     next_load             : downstream stage will load this cycle
//     load                  : this stage loads this cycle (empty or advancing)
//     valid/code/res        : this stage register (partial code d[1..STAGE])
module nbcac_enc_stage
  import nbcac_pkg::*;
#(
  parameter int CODE_W = 8,
  parameter int RES_W  = 7,
  parameter int STAGE  = 2,
  parameter int W_K    = 26,
  parameter int W_NEXT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prev_valid,
  input  logic [CODE_W-1:0] prev_code,
  input  logic [RES_W-1:0]  prev_res,
  input  logic              next_load,
  output logic              load,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [RES_W-1:0]  res
);

  localparam logic [RES_W-1:0] W_K_V  = RES_W'(W_K);
  localparam logic [RES_W-1:0] W_HI_V = RES_W'(W_K + W_NEXT);

  logic              valid_r;
  logic [CODE_W-1:0] code_r;
  logic [RES_W-1:0]  res_r;
  logic              bit_s;
  logic [RES_W-1:0]  res_nxt_s;
  logic [CODE_W-1:0] code_nxt_s;

  // An empty stage, or one whose word moves on this cycle, can take a new one.
  assign load  = ~valid_r | next_load;
  assign valid = valid_r;
  assign code  = code_r;
  assign res   = res_r;

  // Bit decision: the ambiguous window [w_k, w_k+w_k+1) repeats the previous
  // bit, which is what keeps isolated 1s/0s out of the codeword.
  always_comb begin
    bit_s      = 1'b0;
    res_nxt_s  = prev_res;
    code_nxt_s = prev_code;
    if (prev_res >= W_HI_V) begin
      bit_s = 1'b1;
    end else if (prev_res < W_K_V) begin
      bit_s = 1'b0;
    end else begin
      bit_s = prev_code[STAGE-2];
    end
    if (bit_s) begin
      res_nxt_s = prev_res - W_K_V;
    end else begin
      res_nxt_s = prev_res;
    end
    code_nxt_s[STAGE-1] = bit_s;
  end

  // Stage register: data only captured for a real word so an empty stage is
  // quiet yet deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      code_r  <= {CODE_W{1'b0}};
      res_r   <= {RES_W{1'b0}};
    end else if (load) begin
      valid_r <= prev_valid;
      if (prev_valid) begin
        code_r <= code_nxt_s;
        res_r  <= res_nxt_s;
      end
    end
  end

endmodule

// File: rtl/nbcac_enc_pipe.sv
// nbcac_enc_pipe
//   Pipelined NBCAC encoder: DATA_W-bit binary word -> CODE_W-bit codeword,
//   one code bit resolved per stage, valid/ready on both sides.
//   Ports:
//     clk, rst_n             : clock, async active-low reset
//     in_valid/in_ready      : input handshake, in_data = binary word
//     out_valid/out_ready    : output handshake, out_code = codeword
//                              (bit 0 = d[1]), out_err = residual check failed
module nbcac_enc_pipe
  import nbcac_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_err
);

  localparam int RES_W  = nbcac_res_w(CODE_W);
  localparam int CAP    = nbcac_capacity(CODE_W);
  localparam int W_LAST = nbcac_weight(CODE_W, CODE_W);
  localparam logic [RES_W-1:0] W_LAST_V = RES_W'(W_LAST);

  if ((CODE_W < NBCAC_MIN_CODE_W) || (((2 ** DATA_W) - 1) > CAP)) begin : g_bad_cfg
    $error("nbcac_enc_pipe: DATA_W/CODE_W combination cannot be encoded");
  end

  // Per-stage views, index = stage number (1 .. CODE_W-1); load_s also covers
  // the final stage.
  logic              vld_s  [1:CODE_W-1];
  logic [CODE_W-1:0] code_s [1:CODE_W-1];
  logic [RES_W-1:0]  res_s  [1:CODE_W-1];
  logic              load_s [1:CODE_W];

  logic              s1_valid_r;
  logic [CODE_W-1:0] s1_code_r;
  logic [RES_W-1:0]  s1_res_r;

  logic              last_valid_s;
  logic [CODE_W-1:0] last_code_s;
  logic [RES_W-1:0]  last_res_s;
  logic              fin_bit_s;
  logic              fin_err_s;
  logic [CODE_W-1:0] fin_code_s;

  logic              out_valid_r;
  logic [CODE_W-1:0] out_code_r;
  logic              out_err_r;

  // ---------------- stage 1: d[1] is the LSB, residual is the even part
  assign load_s[1] = ~s1_valid_r | load_s[2];
  assign in_ready  = load_s[1];
  assign vld_s[1]  = s1_valid_r;
  assign code_s[1] = s1_code_r;
  assign res_s[1]  = s1_res_r;

  // Stage-1 register: captures the accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_code_r  <= {CODE_W{1'b0}};
      s1_res_r   <= {RES_W{1'b0}};
    end else if (load_s[1]) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_code_r <= {{(CODE_W-1){1'b0}}, in_data[0]};
        s1_res_r  <= RES_W'({in_data[DATA_W-1:1], 1'b0});
      end
    end
  end

  // ---------------- stages 2 .. CODE_W-1
  for (genvar k = 2; k <= CODE_W - 1; k++) begin : g_stage
    nbcac_enc_stage #(
      .CODE_W (CODE_W),
      .RES_W  (RES_W),
      .STAGE  (k),
      .W_K    (nbcac_weight(CODE_W, k)),
      .W_NEXT (nbcac_weight(CODE_W, k + 1))
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .prev_valid (vld_s[k-1]),
      .prev_code  (code_s[k-1]),
      .prev_res   (res_s[k-1]),
      .next_load  (load_s[k+1]),
      .load       (load_s[k]),
      .valid      (vld_s[k]),
      .code       (code_s[k]),
      .res        (res_s[k])
    );
  end

  // ---------------- final stage: top bit absorbs whatever residual is left
  assign last_valid_s     = vld_s[CODE_W-1];
  assign last_code_s      = code_s[CODE_W-1];
  assign last_res_s       = res_s[CODE_W-1];
  assign load_s[CODE_W]   = ~out_valid_r | out_ready;

  // Final bit and residual check: a legal leftover is either 0 or w[CODE_W].
  always_comb begin
    fin_bit_s  = 1'b0;
    fin_err_s  = 1'b0;
    fin_code_s = last_code_s;
    if (last_res_s != {RES_W{1'b0}}) begin
      fin_bit_s = 1'b1;
    end else begin
      fin_bit_s = 1'b0;
    end
    if ((last_res_s == {RES_W{1'b0}}) || (last_res_s == W_LAST_V)) begin
      fin_err_s = 1'b0;
    end else begin
      fin_err_s = 1'b1;
    end
    fin_code_s[CODE_W-1] = fin_bit_s;
  end

  // Output register: holds code/err steady while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_code_r  <= {CODE_W{1'b0}};
      out_err_r   <= 1'b0;
    end else if (load_s[CODE_W]) begin
      out_valid_r <= last_valid_s;
      if (last_valid_s) begin
        out_code_r <= fin_code_s;
        out_err_r  <= fin_err_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_code  = out_code_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_nbcac_enc_pipe.sv
// tb_nbcac_enc_pipe
//   Self-checking bench for nbcac_enc_pipe: a 6->8 instance (dut_a) and a
//   7->10 instance (dut_b), each against a weight-table reference encoder,
//   an independent weighted-sum decode and a no-isolated-bit pattern check.
//   The weight/tie rule guarantees no 010/101 inside a codeword; it does not
//   exclude opposite transitions between consecutive words (e.g. 0x60 -> 0x80),
//   so the pattern check is applied within each word.
module tb_nbcac_enc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_err_a;
  logic [5:0] in_data_a;
  logic [7:0] out_code_a;
  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_err_b;
  logic [6:0] in_data_b;
  logic [9:0] out_code_b;

  nbcac_enc_pipe #(.DATA_W(6), .CODE_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_code(out_code_a), .out_err(out_err_a));

  nbcac_enc_pipe #(.DATA_W(7), .CODE_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_code(out_code_b), .out_err(out_err_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int qd_a[$];
  int qc_a[$];
  int q_b[$];
  int lat_chk, fault_on, fault_data, outs_a, outs_b, sent, t3;
  logic acc_a, acc_b, stall_prev, stall_err;
  logic [7:0] stall_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Weight table for an n-bit code.
  function automatic int wgt(input int n, input int k);
    int w [1:16];
    for (int j = 1; j <= 16; j++) w[j] = 0;
    w[n] = 2;
    w[n-1] = 2;
    for (int j = n - 2; j >= 2; j--) w[j] = w[j+1] + w[j+2];
    w[1] = 1;
    return w[k];
  endfunction

  // Reference encoder straight from the weight/decision rules.
  function automatic logic [15:0] ref_code(input int n, input int v);
    int r, d, prevb;
    logic [15:0] c;
    c = 16'h0;
    prevb = v % 2;
    c[0] = (prevb != 0);
    r = v - prevb;
    for (int k = 2; k <= n - 1; k++) begin
      if (r >= wgt(n, k) + wgt(n, k + 1)) d = 1;
      else if (r < wgt(n, k)) d = 0;
      else d = prevb;
      r = r - d * wgt(n, k);
      c[k-1] = (d != 0);
      prevb = d;
    end
    c[n-1] = (r != 0);
    return c;
  endfunction

  function automatic int decode(input int n, input logic [15:0] c);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) if (c[i]) s = s + wgt(n, i + 1);
    return s;
  endfunction

  function automatic int pattern_ok(input int n, input logic [15:0] c);
    int ok;
    ok = 1;
    for (int i = 0; i + 2 < n; i++)
      if ((c[i+:3] == 3'b010) || (c[i+:3] == 3'b101)) ok = 0;
    return ok;
  endfunction

  // Hand-derived codewords for a few 6-bit inputs.
  function automatic int spot(input int d, output logic [7:0] e);
    int has;
    has = 1;
    case (d)
      0:  e = 8'h00;
      1:  e = 8'h01;
      2:  e = 8'h80;
      32: e = 8'h1C;
      63: e = 8'h3F;
      default: begin e = 8'h00; has = 0; end
    endcase
    return has;
  endfunction

  // One clock: sample at the falling edge, score handshakes, advance.
  task automatic step();
    int d, c;
    logic [15:0] e;
    logic [7:0] s;
    @(negedge clk);
    acc_a = in_valid_a && in_ready_a;
    acc_b = in_valid_b && in_ready_b;
    if (stall_prev) begin
      check("stall_valid", out_valid_a, 1);
      check("stall_code", out_code_a, stall_code);
      check("stall_err", out_err_a, stall_err);
    end
    stall_prev = out_valid_a && !out_ready_a;
    stall_code = out_code_a;
    stall_err  = out_err_a;
    if (acc_a) begin qd_a.push_back(int'(in_data_a)); qc_a.push_back(cyc); end
    if (acc_b) q_b.push_back(int'(in_data_b));
    if (out_valid_a && out_ready_a) begin
      outs_a++;
      if (qd_a.size() == 0) begin
        check("a_spurious_out", out_valid_a, 0);
      end else begin
        d = qd_a.pop_front();
        c = qc_a.pop_front();
        e = ref_code(8, d);
        if ((fault_on != 0) && (d == fault_data)) begin
          e[7] = 1'b1;
          check("a_fault_err", out_err_a, 1);
        end else begin
          check("a_err", out_err_a, 0);
          check("a_decode", decode(8, 16'(out_code_a)), d);
          check("a_pattern", pattern_ok(8, 16'(out_code_a)), 1);
          if (spot(d, s) != 0) check("a_spot", out_code_a, s);
        end
        check("a_code", out_code_a, e[7:0]);
        if (lat_chk != 0) check("a_latency", cyc - (c + 1), 7);
      end
    end
    if (out_valid_b && out_ready_b) begin
      outs_b++;
      if (q_b.size() == 0) begin
        check("b_spurious_out", out_valid_b, 0);
      end else begin
        d = q_b.pop_front();
        e = ref_code(10, d);
        check("b_code", out_code_b, e[9:0]);
        check("b_err", out_err_b, 0);
        check("b_decode", decode(10, 16'(out_code_b)), d);
        check("b_pattern", pattern_ok(10, 16'(out_code_b)), 1);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_a = 1'b0; in_data_a = 6'd0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = 7'd127; out_ready_b = 1'b1;
    lat_chk = 0; fault_on = 0; fault_data = 0; outs_a = 0; outs_b = 0;
    stall_prev = 1'b0; stall_err = 1'b0; stall_code = 8'h00;
    acc_a = 1'b0; acc_b = 1'b0; sent = 0; t3 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_code", out_code_a, 0);
    check("rst_out_err", out_err_a, 0);
    check("rst_out_valid_b", out_valid_b, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_a, 1);

    // Exhaustive back-to-back sweep, unstalled
    out_ready_a = 1'b1;
    lat_chk = 1;
    for (int v = 0; v < 64; v++) begin
      in_valid_a = 1'b1;
      in_data_a = 6'(v);
      step();
      check("sweep_accept", acc_a, 1);
    end
    in_valid_a = 1'b0;
    for (int i = 0; i < 40 && qd_a.size() > 0; i++) step();
    check("sweep_drained", qd_a.size(), 0);
    check("sweep_count", outs_a, 64);

    // Backpressure: 20 words offered with the sink stalled
    lat_chk = 0;
    out_ready_a = 1'b0;
    in_valid_a = 1'b1;
    in_data_a = 6'($urandom);
    sent = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (acc_a) begin sent++; in_data_a = 6'($urandom); end
    end
    check("bp_accepts", sent, 8);
    check("bp_in_ready_low", in_ready_a, 0);
    check("bp_out_valid", out_valid_a, 1);
    out_ready_a = 1'b1;
    for (int i = 0; i < 40 && sent < 20; i++) begin
      step();
      check("bp_resume_rate", acc_a, 1);
      if (acc_a) begin sent++; in_data_a = 6'($urandom); end
    end
    in_valid_a = 1'b0;
    for (int i = 0; i < 40 && qd_a.size() > 0; i++) step();
    check("bp_drained", qd_a.size(), 0);

    // Random valid/ready on dut_a, continuous random stream on dut_b
    in_valid_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid_a = 1'($urandom_range(0, 1));
      out_ready_a = 1'($urandom_range(0, 1));
      step();
      if (acc_a) in_data_a = 6'($urandom);
      if (acc_b) in_data_b = 7'($urandom);
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    out_ready_a = 1'b1;
    for (int i = 0; i < 60 && (qd_a.size() > 0 || q_b.size() > 0); i++) step();
    check("rand_drained_a", qd_a.size(), 0);
    check("rand_drained_b", q_b.size(), 0);
    check("b_seen", outs_b > 250, 1);

    // Asynchronous reset with 5 words in flight
    out_ready_a = 1'b0;
    in_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data_a = 6'($urandom);
      step();
      check("mid_accept", acc_a, 1);
    end
    in_valid_a = 1'b0;
    for (int i = 0; i < 20 && !out_valid_a; i++) step();
    check("mid_filled", out_valid_a, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_a, 0);
    check("mid_rst_code", out_code_a, 0);
    check("mid_rst_err", out_err_a, 0);
    qd_a.delete();
    qc_a.delete();
    stall_prev = 1'b0;
    outs_a = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_in_ready", in_ready_a, 1);
    out_ready_a = 1'b1;
    repeat (20) step();
    check("mid_no_ghost", outs_a, 0);

    // Fault injection: illegal final residual on the third of four words
    lat_chk = 1;
    fault_data = 30;
    fault_on = 1;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_a = 6'((i + 1) * 10);
      step();
      check("fault_accept", acc_a, 1);
      if (i == 2) t3 = cyc;
    end
    in_valid_a = 1'b0;
    for (int i = 0; i < 20 && cyc < t3 + 6; i++) step();
    force dut_a.last_res_s = 7'd1;
    step();
    release dut_a.last_res_s;
    for (int i = 0; i < 20 && qd_a.size() > 0; i++) step();
    check("fault_drained", qd_a.size(), 0);
    fault_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
